launch_control: RTL and testbench
=================================

LAUNCH_CONTROL -- requirements
Module: launch_control

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of stable clk cycles before a button press is accepted.
REQ-002 Parameter POWER_STEP, default 25, is the power increment/decrement per accepted press.
REQ-003 Parameter POWER_MAX, default 500, is the power saturation ceiling.
REQ-004 Parameter POWER_INIT, default 250, is the power value after reset.
REQ-005 clk  in  1  system clock; reset rst, synchronous, active-high; clock clk.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 btn_up, btn_down, btn_left, btn_right, btn_fire  in  1 each  raw asynchronous push-buttons, active-high.
REQ-008 update  in  1  trajectory step strobe, the same signal that clocks the ball stage, asynchronous to clk.
REQ-009 landed  in  1  level from the ball stage, high once the ball has reached ground.
REQ-010 vel_x, vel_y  out  10 each  launch velocity components fed to the ball stage.
REQ-011 power  out  10  current power setting.
REQ-012 angle_idx  out  4  current angle index 0..8, one step per 10 degrees.
REQ-013 go  out  1  level launch request to the ball stage.
REQ-014 ball_rst  out  1  reset request to the ball stage.
REQ-015 busy  out  1  high in every state except AIM.

Function
REQ-016 Each btn_* input SHALL pass through a 2-flop synchronizer, followed by a per-button debounce counter.
REQ-017 A press SHALL be accepted as a 1-cycle pulse once the synchronized input has been high for DEBOUNCE_CYCLES consecutive cycles; the counter clears on any low sample; there is no auto-repeat.
REQ-018 update SHALL be 2-flop synchronized; a rising edge SHALL be detected as a 1-cycle pulse.
REQ-019 The FSM SHALL have four states, AIM, FLIGHT, LANDED and REARM, with these transitions.
  - AIM->FLIGHT on fire press.
  - FLIGHT->LANDED when landed=1.
  - LANDED->REARM on fire press.
  - REARM->AIM after the second update rising edge counted inside REARM.
REQ-020 In AIM, up/down presses SHALL change power by +/-POWER_STEP, saturating at POWER_MAX and 0.
REQ-021 In AIM, right/left presses SHALL change angle_idx by +/-1, saturating at 8 and 0.
REQ-022 Simultaneous up+down presses in the same cycle SHALL leave power unchanged; simultaneous left+right presses SHALL leave angle_idx unchanged.
REQ-023 A fire press in the same cycle as an adjust press SHALL win: the adjust is discarded and the launch uses the pre-adjust values.
REQ-024 Adjust presses in FLIGHT, LANDED and REARM SHALL be ignored; power, angle_idx, vel_x and vel_y are frozen.
REQ-025 go SHALL be 1 only in FLIGHT; it rises the cycle after the fire press and falls the cycle after landed is sampled high.
REQ-026 ball_rst SHALL be 1 only in REARM; busy SHALL be 0 only in AIM.
REQ-027 Velocities SHALL use fixed Q8 tables indexed by angle_idx 0..8.
  - COS = 256, 252, 241, 222, 196, 165, 128, 88, 44.
  - SIN = 0, 44, 88, 128, 165, 196, 222, 241, 252.
REQ-028 vel_x SHALL equal (power*COS[angle_idx])>>8 and vel_y SHALL equal (power*SIN[angle_idx])>>8, computed with a 19-bit product, truncated and registered.
REQ-029 vel_x and vel_y SHALL be valid 1 clk cycle after power or angle_idx changes.
REQ-030 With power at most 500, both results fit in 10 bits; no clipping is required.
REQ-031 A landed level that is already high on entry to FLIGHT SHALL move the FSM to LANDED on the next cycle.
REQ-032 A fire press during FLIGHT or REARM SHALL be ignored.

Reset
REQ-033 On rst the block SHALL set: state=AIM, power=POWER_INIT, angle_idx=4, vel_x=191, vel_y=161, go=0, ball_rst=0, busy=0.
REQ-034 On rst the block SHALL clear all synchronizers, debounce counters and the update edge count.
REQ-035 rst asserted in any state, including mid-FLIGHT, SHALL take effect on the next clk edge; go drops to 0 at that edge.

Verification (DEBOUNCE_CYCLES=4)
REQ-036 Release rst -> power=250, angle_idx=4, vel_x=191, vel_y=161, go=0, busy=0.
REQ-037 Eleven up presses, then four right presses -> power saturates at 500, angle_idx=8, vel_x=85, vel_y=492.
REQ-038 From reset, ten down presses, one up press, then four left presses -> power=25, angle_idx=0, vel_x=25, vel_y=0.
REQ-039 A 3-cycle glitch on btn_up -> no power change; up and down asserted together for 6 cycles -> no power change.
REQ-040 fire+up accepted in the same cycle -> go=1 next cycle, power unchanged at 250; landed=1 -> go=0 next cycle.
REQ-041 After REQ-040, fire in LANDED -> ball_rst=1 until the 2nd update rising edge, then AIM with busy=0.
REQ-042 rst pulsed mid-FLIGHT -> go=0 and all outputs at reset values at the next clk edge.

Source files
------------

// File: rtl/launch_control.sv
// Launch controller: debounced aim buttons, power/angle setting with Q8 trig
// velocity lookup, and the AIM/FLIGHT/LANDED/REARM sequencing toward the ball stage.

module lc_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter parks at CYCLES while held, so a long press fires exactly once.
  always_comb begin
    sync_d = {sync_q[0], raw};
    cnt_d  = cnt_q;
    pulse  = 1'b0;
    if (!sync_q[1]) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(CYCLES)) begin
      cnt_d = cnt_q + 1'b1;
      pulse = (cnt_q == CW'(CYCLES - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

module launch_control #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int POWER_STEP      = 25,
  parameter int POWER_MAX       = 500,
  parameter int POWER_INIT      = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_fire,
  input  logic       update,
  input  logic       landed,
  output logic [9:0] vel_x,
  output logic [9:0] vel_y,
  output logic [9:0] power,
  output logic [3:0] angle_idx,
  output logic       go,
  output logic       ball_rst,
  output logic       busy
);
  localparam int NUM_BTN = 5;
  localparam int B_UP = 0, B_DN = 1, B_LT = 2, B_RT = 3, B_FIRE = 4;
  localparam logic [3:0] ANGLE_INIT = 4'd4;
  localparam logic [3:0] ANGLE_MAX  = 4'd8;

  typedef enum logic [1:0] {AIM, FLIGHT, LANDED, REARM} state_t;

  function automatic logic [8:0] cos_q8(input logic [3:0] i);
    case (i)
      4'd0: cos_q8 = 9'd256;  4'd1: cos_q8 = 9'd252;  4'd2: cos_q8 = 9'd241;
      4'd3: cos_q8 = 9'd222;  4'd4: cos_q8 = 9'd196;  4'd5: cos_q8 = 9'd165;
      4'd6: cos_q8 = 9'd128;  4'd7: cos_q8 = 9'd88;   4'd8: cos_q8 = 9'd44;
      default: cos_q8 = 9'd0;
    endcase
  endfunction

  function automatic logic [8:0] sin_q8(input logic [3:0] i);
    case (i)
      4'd0: sin_q8 = 9'd0;    4'd1: sin_q8 = 9'd44;   4'd2: sin_q8 = 9'd88;
      4'd3: sin_q8 = 9'd128;  4'd4: sin_q8 = 9'd165;  4'd5: sin_q8 = 9'd196;
      4'd6: sin_q8 = 9'd222;  4'd7: sin_q8 = 9'd241;  4'd8: sin_q8 = 9'd252;
      default: sin_q8 = 9'd0;
    endcase
  endfunction

  localparam logic [18:0] RST_PX = 19'(POWER_INIT) * 19'd196;
  localparam logic [18:0] RST_PY = 19'(POWER_INIT) * 19'd165;

  logic [NUM_BTN-1:0] btn_raw, press;
  assign btn_raw = {btn_fire, btn_right, btn_left, btn_down, btn_up};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    lc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[g]),
      .pulse (press[g])
    );
  end

  // update comes from another clock domain: sync, then keep one extra stage for edge detect.
  logic [2:0] upd_sync_q, upd_sync_d;
  logic       upd_rise;
  assign upd_sync_d = {upd_sync_q[1:0], update};
  assign upd_rise   = upd_sync_q[1] & ~upd_sync_q[2];

  state_t      state_q;
  logic        go_q, ball_rst_q, busy_q, upd_cnt_q;
  logic [9:0]  power_q, power_d;
  logic [3:0]  angle_q, angle_d;
  logic [9:0]  vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  logic [10:0] power_up;
  logic [18:0] prod_x, prod_y;

  // A fire press in AIM wins over any adjust in the same cycle.
  always_comb begin
    power_d  = power_q;
    angle_d  = angle_q;
    power_up = {1'b0, power_q} + 11'(POWER_STEP);
    if (state_q == AIM && !press[B_FIRE]) begin
      if (press[B_UP] && !press[B_DN])
        power_d = (power_up > 11'(POWER_MAX)) ? 10'(POWER_MAX) : power_up[9:0];
      else if (press[B_DN] && !press[B_UP])
        power_d = (power_q < 10'(POWER_STEP)) ? 10'd0 : power_q - 10'(POWER_STEP);
      if (press[B_RT] && !press[B_LT])
        angle_d = (angle_q == ANGLE_MAX) ? ANGLE_MAX : angle_q + 4'd1;
      else if (press[B_LT] && !press[B_RT])
        angle_d = (angle_q == 4'd0) ? 4'd0 : angle_q - 4'd1;
    end
    prod_x  = 19'(power_q) * 19'(cos_q8(angle_q));
    prod_y  = 19'(power_q) * 19'(sin_q8(angle_q));
    vel_x_d = 10'(prod_x >> 8);
    vel_y_d = 10'(prod_y >> 8);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_sync_q <= '0;
      power_q    <= 10'(POWER_INIT);
      angle_q    <= ANGLE_INIT;
      vel_x_q    <= 10'(RST_PX >> 8);
      vel_y_q    <= 10'(RST_PY >> 8);
    end else begin
      upd_sync_q <= upd_sync_d;
      power_q    <= power_d;
      angle_q    <= angle_d;
      vel_x_q    <= vel_x_d;
      vel_y_q    <= vel_y_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= AIM;
      go_q       <= 1'b0;
      ball_rst_q <= 1'b0;
      busy_q     <= 1'b0;
      upd_cnt_q  <= 1'b0;
    end else begin
      case (state_q)
        AIM: if (press[B_FIRE]) begin
          state_q <= FLIGHT;
          go_q    <= 1'b1;
          busy_q  <= 1'b1;
        end
        FLIGHT: if (landed) begin
          state_q <= LANDED;
          go_q    <= 1'b0;
        end
        LANDED: if (press[B_FIRE]) begin
          state_q    <= REARM;
          ball_rst_q <= 1'b1;
          upd_cnt_q  <= 1'b0;
        end
        REARM: if (upd_rise) begin
          if (upd_cnt_q) begin
            state_q    <= AIM;
            ball_rst_q <= 1'b0;
            busy_q     <= 1'b0;
            upd_cnt_q  <= 1'b0;
          end else begin
            upd_cnt_q <= 1'b1;
          end
        end
        default: state_q <= AIM;
      endcase
    end
  end

  assign vel_x     = vel_x_q;
  assign vel_y     = vel_y_q;
  assign power     = power_q;
  assign angle_idx = angle_q;
  assign go        = go_q;
  assign ball_rst  = ball_rst_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_launch_control.sv
// Directed bench for launch_control with a short debounce window.

module tb_launch_control;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_fire = 0;
  logic       update = 0, landed = 0;
  logic [9:0] vel_x, vel_y, power;
  logic [3:0] angle_idx;
  logic       go, ball_rst, busy;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [4:0] UP = 5'b00001, DN = 5'b00010, LT = 5'b00100,
                         RT = 5'b01000, FIRE = 5'b10000;

  launch_control #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_fire(btn_fire),
    .update(update), .landed(landed),
    .vel_x(vel_x), .vel_y(vel_y), .power(power), .angle_idx(angle_idx),
    .go(go), .ball_rst(ball_rst), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input logic [4:0] m);
    {btn_fire, btn_right, btn_left, btn_down, btn_up} = m;
  endtask

  task automatic press(input logic [4:0] m, input int hold);
    set_btn(m);
    cyc(hold);
    set_btn(5'b0);
    cyc(5);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic chk_all(input string tag, input int p, input int a, input int vx, input int vy);
    chk({tag, ".power"}, int'(power), p);
    chk({tag, ".angle"}, int'(angle_idx), a);
    chk({tag, ".vel_x"}, int'(vel_x), vx);
    chk({tag, ".vel_y"}, int'(vel_y), vy);
  endtask

  task automatic pulse_update();
    update = 1'b1;
    cyc(3);
    update = 1'b0;
    cyc(3);
  endtask

  initial begin
    int n;
    @(posedge clk); #1;
    do_reset();

    // Reset state
    chk_all("reset", 250, 4, 191, 161);
    chk("reset.go", int'(go), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.ball_rst", int'(ball_rst), 0);

    // Power ceiling and angle ceiling
    for (int i = 0; i < 11; i++) press(UP, 8);
    chk("up11.power", int'(power), 500);
    for (int i = 0; i < 4; i++) press(RT, 8);
    chk_all("max", 500, 8, 85, 492);
    press(RT, 8);
    chk("rt_sat.angle", int'(angle_idx), 8);

    // Power floor and angle floor
    do_reset();
    for (int i = 0; i < 10; i++) press(DN, 8);
    chk("dn10.power", int'(power), 0);
    press(DN, 8);
    chk("dn_sat.power", int'(power), 0);
    press(UP, 8);
    for (int i = 0; i < 4; i++) press(LT, 8);
    chk_all("min", 25, 0, 25, 0);
    press(LT, 8);
    chk("lt_sat.angle", int'(angle_idx), 0);

    // Glitch rejection and simultaneous opposing presses
    do_reset();
    press(UP, 3);
    chk("glitch.power", int'(power), 250);
    press(UP | DN, 6);
    chk("updn.power", int'(power), 250);
    press(LT | RT, 6);
    chk("ltrt.angle", int'(angle_idx), 4);
    press(UP, 40);
    chk("held.power", int'(power), 275);
    press(DN, 8);

    // Fire with up in the same cycle: launch wins, exact go latency
    set_btn(FIRE | UP);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (go) begin n = i; break; end
    end
    chk("fire.go_latency", n, 6);
    set_btn(5'b0);
    cyc(5);
    chk("fire.go", int'(go), 1);
    chk("fire.busy", int'(busy), 1);
    chk_all("fire", 250, 4, 191, 161);

    // Adjust and fire ignored in FLIGHT
    press(UP, 8);
    press(RT, 8);
    chk_all("flight_frozen", 250, 4, 191, 161);
    press(FIRE, 8);
    chk("flight_fire.go", int'(go), 1);

    // Landed drops go on the next edge
    landed = 1'b1;
    chk("landed.go_before", int'(go), 1);
    cyc(1);
    chk("landed.go", int'(go), 0);
    chk("landed.busy", int'(busy), 1);
    chk("landed.ball_rst", int'(ball_rst), 0);

    // Rearm sequence: exits only on the second update edge
    press(FIRE, 8);
    landed = 1'b0;
    chk("rearm.ball_rst", int'(ball_rst), 1);
    chk("rearm.busy", int'(busy), 1);
    press(FIRE, 8);
    chk("rearm_fire.ball_rst", int'(ball_rst), 1);
    pulse_update();
    chk("rearm_1st_upd.ball_rst", int'(ball_rst), 1);
    pulse_update();
    chk("rearm_2nd_upd.ball_rst", int'(ball_rst), 0);
    chk("rearm_2nd_upd.busy", int'(busy), 0);
    press(UP, 8);
    chk("aim_again.power", int'(power), 275);

    // Landed already high when FLIGHT is entered
    landed = 1'b1;
    set_btn(FIRE);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (go) begin n = i; break; end
    end
    chk("prelanded.go_rise", n, 6);
    cyc(1);
    chk("prelanded.go_fall", int'(go), 0);
    chk("prelanded.busy", int'(busy), 1);
    set_btn(5'b0);
    landed = 1'b0;

    // Reset mid-FLIGHT
    do_reset();
    press(RT, 8);
    press(FIRE, 8);
    chk("midflight.go", int'(go), 1);
    rst = 1'b1;
    cyc(1);
    chk("midflight_rst.go", int'(go), 0);
    chk("midflight_rst.busy", int'(busy), 0);
    chk("midflight_rst.ball_rst", int'(ball_rst), 0);
    chk_all("midflight_rst", 250, 4, 191, 161);
    rst = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
